// File: rtl/memory_stage.sv
// memory_stage: load/store unit between execute and writeback of an RV32I pipe.
//
// Ports
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   ex_valid                an instruction from execute is present this cycle
//   ex_result[31:0]         address for loads/stores, writeback value otherwise
//   ex_op2_selected[31:0]   store data (rs2, unaligned in the low bits)
//   ex_func3[2:0]           RV32I access size / sign
//   ex_mem_read/_write      load / store qualifiers (never both high)
//   flush                   kill the current instruction's writeback
//   dmem_req/we/addr/wdata/wstrb, dmem_ack, dmem_rdata   data-memory bus
//   mem_stall               upstream holds every ex_* input while high
//   wb_valid, wb_data, misalign_err   registered writeback (single-cycle pulses)
//
// Bus handshake: a request is presented while dmem_req=1 (state WAIT) with
// we/addr/wdata/wstrb held stable; the transfer completes in the cycle
// dmem_ack=1. dmem_rdata is sampled only in that cycle and ack is ignored
// when no request is outstanding.
module memory_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_op2_selected,
  input  logic [2:0]  ex_func3,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state;
  state_t      state_next;

  logic        is_mem;
  logic        legal;
  logic        aligned;
  logic        take;        // live instruction in IDLE, not flushed
  logic        access;      // goes to the bus
  logic        bad_access;  // memory op rejected (illegal func3 or misaligned)
  logic        pass_thru;   // non-memory instruction

  logic [3:0]  store_strb;
  logic [31:0] store_data;
  logic [2:0]  cap_func3;
  logic [1:0]  cap_lo;
  logic        kill;
  logic [31:0] shifted;
  logic [31:0] load_val;

  // ---------------- instruction classification ----------------
  assign is_mem = ex_mem_read | ex_mem_write;

  always_comb begin
    legal = 1'b0;
    if (ex_mem_read)
      legal = ex_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (ex_mem_write)
      legal = ex_func3 inside {3'b000, 3'b001, 3'b010};
  end

  always_comb begin
    case (ex_func3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ex_result[0];
      default: aligned = (ex_result[1:0] == 2'b00);
    endcase
  end

  assign take       = (state == S_IDLE) & ex_valid & ~flush;
  assign access     = take & is_mem & legal & aligned;
  assign bad_access = take & is_mem & ~(legal & aligned);
  assign pass_thru  = take & ~is_mem;

  // ---------------- store lane placement ----------------
  always_comb begin
    store_strb = 4'b1111;
    store_data = ex_op2_selected;
    case (ex_func3[1:0])
      2'b00: begin
        store_strb = 4'b0001 << ex_result[1:0];
        store_data = {4{ex_op2_selected[7:0]}};
      end
      2'b01: begin
        store_strb = 4'b0011 << ex_result[1:0];
        store_data = {2{ex_op2_selected[15:0]}};
      end
      default: ;
    endcase
  end

  // ---------------- load extraction (valid only in the ack cycle) ----------------
  always_comb begin
    shifted = dmem_rdata >> {cap_lo, 3'b000};
    case (cap_func3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h000000, shifted[7:0]};
      3'b101:  load_val = {16'h0000, shifted[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (access)   state_next = S_WAIT;
      S_WAIT:  if (dmem_ack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // The accept cycle stalls too, so the ex_* inputs stay put while the
  // request is registered; in WAIT the stall drops in the ack cycle.
  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    case (state)
      S_IDLE: mem_stall = access;
      S_WAIT: begin
        dmem_req  = 1'b1;
        mem_stall = ~dmem_ack;
      end
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_wdata   <= 32'h0;
      dmem_wstrb   <= 4'h0;
      cap_func3    <= 3'b000;
      cap_lo       <= 2'b00;
      kill         <= 1'b0;
      wb_valid     <= 1'b0;
      wb_data      <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;

      if (access) begin
        dmem_we    <= ex_mem_write;
        dmem_addr  <= {ex_result[31:2], 2'b00};
        dmem_wdata <= ex_mem_write ? store_data : 32'h0;
        dmem_wstrb <= ex_mem_write ? store_strb : 4'h0;
        cap_func3  <= ex_func3;
        cap_lo     <= ex_result[1:0];
        kill       <= 1'b0;
      end

      if (pass_thru) begin
        wb_valid <= 1'b1;
        wb_data  <= ex_result;
      end

      if (bad_access) begin
        wb_valid     <= 1'b1;
        misalign_err <= 1'b1;
        wb_data      <= 32'h0;
      end

      // A flush while waiting cannot cancel the bus transfer, so it is
      // remembered in kill; a flush in the ack cycle itself also counts.
      if (state == S_WAIT) begin
        if (dmem_ack) begin
          kill <= 1'b0;
          if (!(kill | flush)) begin
            wb_valid <= 1'b1;
            wb_data  <= dmem_we ? 32'h0 : load_val;
          end
        end else if (flush) begin
          kill <= 1'b1;
        end
      end
    end
  end

endmodule
